// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port-0 arbiter.
//   - default SRAM geometry (DATA_WIDTH, ADDR_WIDTH)
//   - state_e : ST_CLEAR (post-reset zero-fill) / ST_RUN (servicing requests)
//   - REQ_CPU / REQ_HOST requester indices
//   - lock_t  : lock-owner encoding {vld, idx}
package sram_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 11;
  localparam int unsigned NUM_REQ        = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // Lock owner: vld=0 means no lock, otherwise idx holds the owning requester.
  typedef struct packed {
    logic vld;
    logic idx;
  } lock_t;

  localparam lock_t LOCK_NONE = '{vld: 1'b0, idx: REQ_CPU};

  function automatic lock_t lock_to(input logic idx);
    lock_t l;
    l.vld = 1'b1;
    l.idx = idx;
    return l;
  endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// sram_arb_rr2: two-way round-robin grant with lock override (combinational).
// Ports:
//   i_valid  [1:0] request valid per requester
//   i_rr_ptr       requester preferred when both are valid
//   i_lock         lock owner; when valid only that requester may be granted
//   o_grant  [1:0] one-hot (or zero) grant
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  input  lock_t      i_lock,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_lock.vld) begin
      // Locked: the owner alone is eligible, even if it is idle this cycle.
      if (i_lock.idx == REQ_HOST) o_grant = {i_valid[1], 1'b0};
      else                        o_grant = {1'b0, i_valid[0]};
    end else if (i_valid == 2'b11) begin
      o_grant = (i_rr_ptr == REQ_HOST) ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_valid;
    end
  end

endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares SRAM port 0 between the CPU data bus (requester 0)
// and the host loader/DMA (requester 1).
// Optional feature macro: SRAM_ARB_CLEAR_EN -- when defined, the array is
// zero-filled after reset before any request is serviced.
// Ports:
//   clk, rst                 clock (same as SRAM clk0), async active-high reset
//   req_valid/ready/we/lock  per-requester handshake and control (2 bits each)
//   req_wmask/addr/wdata     packed per-requester fields, requester 0 in low bits
//   rsp_valid [1:0]          read data valid, the cycle after a read is accepted
//   rsp_rdata                shared read data, qualified by rsp_valid
//   clear_done               array initialised, requests are serviced
//   sram_*0                  SRAM port 0 pins (csb0/web0 active low)
module sram_port0_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0]                       req_we,
  input  logic [1:0]                       req_lock,
  input  logic [2*(DATA_WIDTH/8)-1:0]      req_wmask,
  input  logic [2*ADDR_WIDTH-1:0]          req_addr,
  input  logic [2*DATA_WIDTH-1:0]          req_wdata,
  output logic [1:0]                       rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             clear_done,
  output logic                             sram_csb0,
  output logic                             sram_web0,
  output logic [(DATA_WIDTH/8)-1:0]        sram_wmask0,
  output logic [ADDR_WIDTH-1:0]            sram_addr0,
  output logic [DATA_WIDTH-1:0]            sram_din0,
  input  logic [DATA_WIDTH-1:0]            sram_dout0
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;
  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;

  state_e                  r_state;
  logic                    r_rr_ptr;
  lock_t                   r_lock;
  logic [1:0]              r_rsp_valid;

  logic [1:0]              w_grant;
  logic                    w_run;
  logic [1:0]              w_ready;
  logic                    w_xfer;
  logic                    w_idx;
  logic                    w_we;
  logic                    w_lock;
  logic [NUM_WMASKS-1:0]   w_wmask;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;

`ifdef SRAM_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic                    r_clear_done;
  logic                    w_clr_last;

  assign w_clr_last = (r_clr_cnt == ADDR_WIDTH'(RAM_DEPTH - 1));
  assign clear_done = r_clear_done;
`else
  assign clear_done = 1'b1;
`endif

  sram_arb_rr2 u_rr2 (
    .i_valid  (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .i_lock   (r_lock),
    .o_grant  (w_grant)
  );

  // Grants are only honoured in RUN and never while reset is held.
  assign w_run     = (r_state == ST_RUN) && !rst;
  assign w_ready   = w_run ? w_grant : 2'b00;
  assign w_xfer    = |w_ready;
  assign w_idx     = w_ready[1];
  assign req_ready = w_ready;

  // Mux the granted requester's fields onto the SRAM side.
  assign w_we    = w_idx ? req_we[1]   : req_we[0];
  assign w_lock  = w_idx ? req_lock[1] : req_lock[0];
  assign w_wmask = w_idx ? req_wmask[2*NUM_WMASKS-1:NUM_WMASKS] : req_wmask[NUM_WMASKS-1:0];
  assign w_addr  = w_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
  assign w_wdata = w_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  // SRAM port 0 pins: the SRAM samples them on the same edge that accepts the beat.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b0;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (rst) begin
      sram_web0 = 1'b1;
`ifdef SRAM_ARB_CLEAR_EN
    end else if (r_state == ST_CLEAR) begin
      sram_csb0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = r_clr_cnt;
`endif
    end else if (w_xfer) begin
      sram_csb0   = 1'b0;
      sram_web0   = !w_we;
      sram_wmask0 = w_wmask;
      sram_addr0  = w_addr;
      sram_din0   = w_wdata;
    end
  end

  // Read data comes straight from the SRAM in the response cycle; zero otherwise.
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = (|r_rsp_valid) ? sram_dout0 : '0;

  // Controller state: clear sequencing, round-robin pointer, lock and responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SRAM_ARB_CLEAR_EN
      r_state      <= ST_CLEAR;
      r_clr_cnt    <= '0;
      r_clear_done <= 1'b0;
`else
      r_state      <= ST_RUN;
`endif
      r_rr_ptr     <= REQ_CPU;
      r_lock       <= LOCK_NONE;
      r_rsp_valid  <= 2'b00;
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
`ifdef SRAM_ARB_CLEAR_EN
        ST_CLEAR: begin
          // Counter wraps to 0 naturally on the last write.
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (w_clr_last) begin
            r_state      <= ST_RUN;
            r_clear_done <= 1'b1;
          end
        end
`endif
        ST_RUN: begin
          if (w_xfer) begin
            r_rr_ptr    <= !w_idx;
            r_lock      <= w_lock ? lock_to(w_idx) : LOCK_NONE;
            r_rsp_valid <= w_we ? 2'b00 : w_ready;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Directed self-checking bench for sram_port0_arbiter with a behavioural SRAM.
// Works with and without SRAM_ARB_CLEAR_EN.
module tb_sram_port0_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 11;
  localparam int unsigned NM    = 2;
  localparam int unsigned DEPTH = 2048;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [1:0]      req_lock = '0;
  logic [2*NM-1:0] req_wmask = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            clear_done;
  logic            sram_csb0;
  logic            sram_web0;
  logic [NM-1:0]   sram_wmask0;
  logic [AW-1:0]   sram_addr0;
  logic [DW-1:0]   sram_din0;
  logic [DW-1:0]   sram_dout0 = '0;

  logic [DW-1:0]   mem [DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_port0_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_wmask   (req_wmask),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .clear_done  (clear_done),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // Behavioural single-port SRAM with byte mask, registered read data.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < int'(NM); b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input logic we, input logic lk,
                       input logic [NM-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]           = v;
    req_we[r]              = we;
    req_lock[r]            = lk;
    req_wmask[r*NM +: NM]  = m;
    req_addr[r*AW +: AW]   = a;
    req_wdata[r*DW +: DW]  = d;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Walk n clear cycles, checking every clear write; requests stay pending.
  task automatic clear_walk(input string tag, input int n);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      #1;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(c) ||
          sram_din0 !== '0 || sram_wmask0 !== 2'b11 || req_ready !== 2'b00 ||
          clear_done !== 1'b0) bad++;
      tick();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic clear_full(input string tag);
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    clear_walk(tag, int'(DEPTH));
    #1;
    check({tag, "_done"}, 32'(clear_done), 32'd1);
    check({tag, "_first_ready"}, 32'(req_ready), 32'd1);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    req_valid = 2'b11;
    req_addr  = {11'd3, 11'd4};
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_csb0", 32'(sram_csb0), 32'd1);
    check("rst_web0", 32'(sram_web0), 32'd1);
    check("rst_addr0", 32'(sram_addr0), 32'd0);
    check("rst_din0", 32'(sram_din0), 32'd0);
    check("rst_wmask0", 32'(sram_wmask0), 32'd0);
`ifdef SRAM_ARB_CLEAR_EN
    check("rst_clear_done", 32'(clear_done), 32'd0);
`else
    check("rst_clear_done", 32'(clear_done), 32'd1);
`endif
    idle();
    rst = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
    clear_full("clear");
`else
    #1;
    check("clear_done_tied", 32'(clear_done), 32'd1);
`endif
  endtask

  logic [DW-1:0] exp_after_rst;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'hDEAD;
    do_reset();
`ifdef SRAM_ARB_CLEAR_EN
    begin
      int nz = 0;
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== '0) nz++;
      check("clear_mem_zero", 32'(nz), 32'd0);
    end
`endif

    // Single write then read by requester 0.
    drive(0, 1'b1, 1'b1, 1'b0, 2'b11, 11'd5, 16'hBEEF);
    #1;
    check("wr_ready", 32'(req_ready), 32'd1);
    check("wr_csb0", 32'(sram_csb0), 32'd0);
    check("wr_web0", 32'(sram_web0), 32'd0);
    check("wr_addr", 32'(sram_addr0), 32'd5);
    check("wr_din", 32'(sram_din0), 32'hBEEF);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd5, 16'h0);
    #1;
    check("rd_ready", 32'(req_ready), 32'd1);
    check("rd_web0", 32'(sram_web0), 32'd1);
    tick();
    idle();
    #1;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    check("idle_csb0", 32'(sram_csb0), 32'd1);
    tick();
    check("rd_rsp_one_cycle", 32'(rsp_valid), 32'd0);

    // Byte mask merge.
    drive(0, 1'b1, 1'b1, 1'b0, 2'b11, 11'd7, 16'h1234);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 2'b10, 11'd7, 16'hAB00);
    #1;
    check("mask_wmask", 32'(sram_wmask0), 32'd2);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd7, 16'h0);
    tick();
    idle();
    #1;
    check("mask_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mask_rdata", 32'(rsp_rdata), 32'hAB34);

    // Preload addresses 1 and 2; rr_ptr ends at requester 0.
    drive(0, 1'b1, 1'b1, 1'b0, 2'b11, 11'd1, 16'h1111);
    tick();
    idle();
    drive(1, 1'b1, 1'b1, 1'b0, 2'b11, 11'd2, 16'h2222);
    #1;
    check("host_wr_ready", 32'(req_ready), 32'd2);
    tick();

    // Contention: grants alternate starting with requester 0.
    drive(0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd1, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 2'b00, 11'd2, 16'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_addr", 32'(sram_addr0), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        check("cont_rsp_valid", 32'(rsp_valid), (k % 2 == 1) ? 32'd1 : 32'd2);
        check("cont_rsp_rdata", 32'(rsp_rdata), (k % 2 == 1) ? 32'h1111 : 32'h2222);
      end
      tick();
    end
    idle();
    #1;
    check("cont_last_rsp_valid", 32'(rsp_valid), 32'd2);
    check("cont_last_rsp_rdata", 32'(rsp_rdata), 32'h2222);

    // Point rr_ptr at requester 1.
    drive(0, 1'b1, 1'b1, 1'b0, 2'b11, 11'd9, 16'h9999);
    tick();

    // Lock: requester 1 runs 3 beats (lock 1,1,0) while requester 0 waits.
    drive(0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd1, 16'h0);
    drive(1, 1'b1, 1'b1, 1'b1, 2'b11, 11'd20, 16'h0A20);
    #1;
    check("lock_b0_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid[1] = 1'b0;
    #1;
    check("lock_owner_idle", 32'(req_ready), 32'd0);
    tick();
    drive(1, 1'b1, 1'b1, 1'b1, 2'b11, 11'd21, 16'h0A21);
    #1;
    check("lock_b1_ready", 32'(req_ready), 32'd2);
    tick();
    drive(1, 1'b1, 1'b1, 1'b0, 2'b11, 11'd22, 16'h0A22);
    #1;
    check("lock_b2_ready", 32'(req_ready), 32'd2);
    tick();
    drive(1, 1'b1, 1'b1, 1'b0, 2'b11, 11'd23, 16'h0A23);
    #1;
    check("unlock_rr_ready", 32'(req_ready), 32'd1);
    check("unlock_rr_addr", 32'(sram_addr0), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 2'b00, 11'd22, 16'h0);
    #1;
    check("unlock_rsp_valid", 32'(rsp_valid), 32'd1);
    check("unlock_rsp_rdata", 32'(rsp_rdata), 32'h1111);
    check("host_rd_ready", 32'(req_ready), 32'd2);
    tick();
    idle();
    #1;
    check("lock_data_valid", 32'(rsp_valid), 32'd2);
    check("lock_data_rdata", 32'(rsp_rdata), 32'h0A22);

    // Reset with a lock held and a read pending at the edge.
    drive(1, 1'b1, 1'b1, 1'b1, 2'b11, 11'd30, 16'h0B30);
    tick();
    req_valid[1] = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd1, 16'h0);
    #1;
    check("lock2_stall", 32'(req_ready), 32'd0);
    drive(1, 1'b1, 1'b0, 1'b0, 2'b00, 11'd1, 16'h0);
    #1;
    check("lock2_owner_rd", 32'(req_ready), 32'd2);
    rst = 1'b1;
    #1;
    check("rst_gates_ready", 32'(req_ready), 32'd0);
    check("rst_gates_csb0", 32'(sram_csb0), 32'd1);
    tick();
    check("rst_inflight_rsp", 32'(rsp_valid), 32'd0);
    check("rst_inflight_rdata", 32'(rsp_rdata), 32'd0);
    do_reset();
    drive(0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd1, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 2'b00, 11'd2, 16'h0);
    #1;
    check("rst_drops_lock", 32'(req_ready), 32'd1);
    tick();
    idle();
`ifdef SRAM_ARB_CLEAR_EN
    exp_after_rst = 16'h0000;
`else
    exp_after_rst = 16'h1111;
`endif
    #1;
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_rdata", 32'(rsp_rdata), 32'(exp_after_rst));
    tick();

`ifdef SRAM_ARB_CLEAR_EN
    // Reset in the middle of the clear restarts it at address 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    clear_walk("midclr_walk", 100);
    #1;
    check("midclr_cnt100", 32'(sram_addr0), 32'd100);
    rst = 1'b1;
    #1;
    check("midclr_rst_csb0", 32'(sram_csb0), 32'd1);
    tick();
    rst = 1'b0;
    clear_full("midclr_restart");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
